motion_actuator: RTL and testbench
==================================

MOTION_ACTUATOR -- requirements
Module: motion_actuator

Interface
REQ-001 SHALL have parameter SERVO_PERIOD, default 2000000, meaning servo frame length in clocks (20 ms at 100 MHz).
REQ-002 SHALL have parameter SERVO_MIN, default 100000, meaning pulse width in clocks for dir code 0.
REQ-003 SHALL have parameter SERVO_STEP, default 16667, meaning extra pulse clocks per dir code.
REQ-004 SHALL have parameter MOTOR_PERIOD, default 5000, meaning motor PWM period in clocks; must be a multiple of 4.
REQ-005 SHALL have parameter DEADTIME, default 50000, meaning H-bridge off time in clocks on a forward/reverse swap.
REQ-006 SHALL have port clk_100, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port dir, input, 3 bits: steering code; 000 full left, 011 straight, 110 full right; 111 is treated as 110.
REQ-009 SHALL have port speed, input, 2 bits: duty level 0..3.
REQ-010 SHALL have port choose, input, 2 bits: 01 forward, 10 reverse, 00 coast, 11 brake.
REQ-011 SHALL have port servo_pwm, output, 1 bit: servo pulse.
REQ-012 SHALL have port motor_pwm, output, 1 bit: H-bridge enable PWM.
REQ-013 SHALL have ports motor_in1 and motor_in2, each output, 1 bit: H-bridge direction pins.
REQ-014 SHALL have port dead_active, output, 1 bit: high while in dead time.

Function
REQ-015 Servo counter SHALL count 0..SERVO_PERIOD-1 and wrap; the frame boundary is at count SERVO_PERIOD-1.
REQ-016 The position register pos (0..6) SHALL update only at the frame boundary, from clamped dir; mid-frame dir changes SHALL NOT alter the current pulse.
REQ-017 servo_pwm SHALL be registered high for exactly SERVO_MIN + pos*SERVO_STEP clocks at the start of each frame, low for the rest of the frame.
REQ-018 Motor counter SHALL count 0..MOTOR_PERIOD-1 and wrap; the duty register SHALL load speed only at the wrap.
REQ-019 Duty high time per period SHALL be: level 0 = 0 clocks, level 1 = MOTOR_PERIOD/4, level 2 = MOTOR_PERIOD/2, level 3 = MOTOR_PERIOD (constant high).
REQ-020 The drive FSM SHALL have states COAST, FWD, REV, BRAKE and DEAD.
REQ-021 Transitions between FWD and REV (either direction) SHALL pass through DEAD.
REQ-022 Any state, including DEAD, SHALL go to COAST on choose 00 and to BRAKE on choose 11 on the next clock.
REQ-023 COAST and BRAKE SHALL go directly to FWD on 01 or to REV on 10.
REQ-024 DEAD SHALL last exactly DEADTIME clocks, then enter the state decoded from choose on that clock; choose changes within 01/10 during DEAD SHALL NOT restart the count.
REQ-025 Registered outputs per state (in1, in2, motor_pwm):
  - FWD: 1, 0, duty
  - REV: 0, 1, duty
  - COAST: 0, 0, 0
  - BRAKE: 1, 1, 1
  - DEAD: 0, 0, 0
REQ-026 dead_active SHALL be high only in DEAD.
REQ-027 motor_in1 and motor_in2 SHALL never both be high outside BRAKE, and SHALL never switch between 10 and 01 without the DEAD gap.

Reset
REQ-028 On rst high at a clock edge, the block SHALL set: all counters 0, pos = 3, duty 0, state COAST, servo_pwm 0, motor_pwm 0, motor_in1 0, motor_in2 0, dead_active 0.
REQ-029 Reset asserted mid-frame or mid-DEAD SHALL abort at once; after release, the first servo frame starts at count 0.

Configuration
REQ-030 With macro SERVO_SLEW_EN defined, pos SHALL move at most one code per frame toward clamped dir.
REQ-031 Without SERVO_SLEW_EN, pos SHALL take clamped dir directly at each frame boundary.

Verification
Bench parameters for all scenarios: SERVO_PERIOD=100, SERVO_MIN=10, SERVO_STEP=5, MOTOR_PERIOD=20, DEADTIME=8.
REQ-032 Reset, then dir=011 -> servo_pwm high 25 clocks of every 100, in1=in2=0.
REQ-033 dir=110 mid-frame, no SERVO_SLEW_EN -> current frame stays 25, next frame 40; with SERVO_SLEW_EN -> frames of 30, 35, 40.
REQ-034 dir=111 -> same 40-clock pulse as 110.
REQ-035 choose=01, speed 1/2/3 -> in1=1, in2=0, motor_pwm high 5/10/20 of every 20 clocks, each level taking effect from the next period wrap.
REQ-036 FWD then choose=10 -> dead_active high and in1=in2=motor_pwm=0 for exactly 8 clocks, then in2=1; choose=11 issued during DEAD -> BRAKE with 1,1,1 next clock.
REQ-037 rst pulsed during DEAD and mid-frame -> all outputs 0 next clock, pos=3, first post-reset pulse 25 clocks.

Source files
------------

// File: rtl/motion_actuator.sv
// motion_actuator: RC-car style servo pulse generator plus an H-bridge drive block.
//
// Servo: a frame counter runs 0..SERVO_PERIOD-1. Each frame starts with a pulse of
// SERVO_MIN + pos*SERVO_STEP clocks. pos is latched from the clamped dir code only
// at the frame boundary.
//
// Motor: a PWM counter runs 0..MOTOR_PERIOD-1. The duty level is latched from speed
// only at the period wrap. A drive FSM maps choose onto the H-bridge pins. Every
// forward/reverse swap is forced through a DEADTIME-clock off gap.
//
// Build option: define SERVO_SLEW_EN to limit pos to one code of travel per frame.
// Without it, pos jumps straight to the clamped dir code at each frame boundary.

module motion_actuator #(
    parameter int unsigned SERVO_PERIOD = 2000000,
    parameter int unsigned SERVO_MIN    = 100000,
    parameter int unsigned SERVO_STEP   = 16667,
    parameter int unsigned MOTOR_PERIOD = 5000,
    parameter int unsigned DEADTIME     = 50000
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic [2:0] dir,
    input  logic [1:0] speed,
    input  logic [1:0] choose,
    output logic       servo_pwm,
    output logic       motor_pwm,
    output logic       motor_in1,
    output logic       motor_in2,
    output logic       dead_active
);

    // Counter widths. The minimum is 1 bit so degenerate parameter values still elaborate.
    localparam int unsigned SCW = (SERVO_PERIOD > 1) ? $clog2(SERVO_PERIOD) : 1;
    localparam int unsigned MCW = (MOTOR_PERIOD > 1) ? $clog2(MOTOR_PERIOD) : 1;
    localparam int unsigned DCW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    // Drive FSM encoding
    localparam logic [2:0] StCoast = 3'd0;
    localparam logic [2:0] StFwd   = 3'd1;
    localparam logic [2:0] StRev   = 3'd2;
    localparam logic [2:0] StBrake = 3'd3;
    localparam logic [2:0] StDead  = 3'd4;

    // choose encodings
    localparam logic [1:0] ChCoast = 2'b00;
    localparam logic [1:0] ChFwd   = 2'b01;
    localparam logic [1:0] ChRev   = 2'b10;
    localparam logic [1:0] ChBrake = 2'b11;

    // ------------------------------------------------------------------
    // Servo path
    // ------------------------------------------------------------------
    logic [SCW-1:0] servo_cnt_q, servo_cnt_d;
    logic [2:0]     pos_q, pos_d;
    logic           servo_pwm_q, servo_pwm_d;
    logic [2:0]     dir_clamped;
    logic           frame_end;
    logic [31:0]    pulse_width;

    // Frame counter, frame-boundary position update and pulse compare
    always_comb begin
        dir_clamped = (dir == 3'd7) ? 3'd6 : dir;
        frame_end   = (servo_cnt_q == SCW'(SERVO_PERIOD - 1));
        servo_cnt_d = frame_end ? '0 : servo_cnt_q + SCW'(1);

        pos_d = pos_q;
        if (frame_end) begin
`ifdef SERVO_SLEW_EN
            if (dir_clamped > pos_q) begin
                pos_d = pos_q + 3'd1;
            end else if (dir_clamped < pos_q) begin
                pos_d = pos_q - 3'd1;
            end
`else
            pos_d = dir_clamped;
`endif
        end

        // The output lags the counter by one clock. After reset (count 0) the first
        // clock already drives a full-width pulse, and each frame sees the pos value
        // latched at the previous boundary.
        pulse_width = SERVO_MIN + 32'(pos_q) * SERVO_STEP;
        servo_pwm_d = (32'(servo_cnt_q) < pulse_width);
    end

    // Servo state registers
    always_ff @(posedge clk_100) begin
        if (rst) begin
            servo_cnt_q <= '0;
            pos_q       <= 3'd3;
            servo_pwm_q <= 1'b0;
        end else begin
            servo_cnt_q <= servo_cnt_d;
            pos_q       <= pos_d;
            servo_pwm_q <= servo_pwm_d;
        end
    end

    // ------------------------------------------------------------------
    // Motor PWM path
    // ------------------------------------------------------------------
    logic [MCW-1:0] motor_cnt_q, motor_cnt_d;
    logic [1:0]     duty_q, duty_d;
    logic           period_end;
    logic [31:0]    high_time;
    logic           duty_on;

    // PWM counter, wrap-aligned duty load and duty compare
    always_comb begin
        period_end  = (motor_cnt_q == MCW'(MOTOR_PERIOD - 1));
        motor_cnt_d = period_end ? '0 : motor_cnt_q + MCW'(1);
        duty_d      = period_end ? speed : duty_q;

        unique case (duty_q)
            2'd0:    high_time = 32'd0;
            2'd1:    high_time = MOTOR_PERIOD / 4;
            2'd2:    high_time = MOTOR_PERIOD / 2;
            default: high_time = MOTOR_PERIOD;
        endcase
        duty_on = (32'(motor_cnt_q) < high_time);
    end

    // ------------------------------------------------------------------
    // Drive FSM
    // ------------------------------------------------------------------
    logic [2:0]     state_q, state_d;
    logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
    logic           dead_done;

    // Next-state logic. COAST and BRAKE requests win from every state, DEAD included.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        dead_done  = (dead_cnt_q == DCW'(DEADTIME - 1));

        unique case (state_q)
            StCoast, StBrake: begin
                unique case (choose)
                    ChCoast: state_d = StCoast;
                    ChFwd:   state_d = StFwd;
                    ChRev:   state_d = StRev;
                    default: state_d = StBrake;
                endcase
            end
            StFwd: begin
                unique case (choose)
                    ChCoast: state_d = StCoast;
                    ChBrake: state_d = StBrake;
                    ChRev: begin
                        state_d    = StDead;
                        dead_cnt_d = '0;
                    end
                    default: state_d = StFwd;
                endcase
            end
            StRev: begin
                unique case (choose)
                    ChCoast: state_d = StCoast;
                    ChBrake: state_d = StBrake;
                    ChFwd: begin
                        state_d    = StDead;
                        dead_cnt_d = '0;
                    end
                    default: state_d = StRev;
                endcase
            end
            StDead: begin
                unique case (choose)
                    ChCoast: state_d = StCoast;
                    ChBrake: state_d = StBrake;
                    default: begin
                        // Flipping between FWD and REV requests keeps counting; the
                        // exit direction is whatever is requested on the final clock.
                        if (dead_done) begin
                            state_d = (choose == ChFwd) ? StFwd : StRev;
                        end else begin
                            dead_cnt_d = dead_cnt_q + DCW'(1);
                        end
                    end
                endcase
            end
            default: state_d = StCoast;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic motor_pwm_q, motor_pwm_d;
    logic in1_q, in1_d;
    logic in2_q, in2_d;
    logic dead_q, dead_d;

    // Outputs are decoded from the next state so pins change on the same edge as the state
    always_comb begin
        motor_pwm_d = 1'b0;
        in1_d       = 1'b0;
        in2_d       = 1'b0;
        dead_d      = 1'b0;
        unique case (state_d)
            StFwd: begin
                in1_d       = 1'b1;
                motor_pwm_d = duty_on;
            end
            StRev: begin
                in2_d       = 1'b1;
                motor_pwm_d = duty_on;
            end
            StBrake: begin
                in1_d       = 1'b1;
                in2_d       = 1'b1;
                motor_pwm_d = 1'b1;
            end
            StDead:  dead_d = 1'b1;
            default: ;
        endcase
    end

    // Motor counters, FSM state and registered pin outputs
    always_ff @(posedge clk_100) begin
        if (rst) begin
            motor_cnt_q <= '0;
            duty_q      <= 2'd0;
            state_q     <= StCoast;
            dead_cnt_q  <= '0;
            motor_pwm_q <= 1'b0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            motor_cnt_q <= motor_cnt_d;
            duty_q      <= duty_d;
            state_q     <= state_d;
            dead_cnt_q  <= dead_cnt_d;
            motor_pwm_q <= motor_pwm_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            dead_q      <= dead_d;
        end
    end

    assign servo_pwm   = servo_pwm_q;
    assign motor_pwm   = motor_pwm_q;
    assign motor_in1   = in1_q;
    assign motor_in2   = in2_q;
    assign dead_active = dead_q;

endmodule

// File: tb/tb_motion_actuator.sv
// Bench for motion_actuator with small parameters. A frame/period-level reference model
// predicts every output on every clock. Directed scenarios add hand-computed pulse widths,
// duty counts and dead-gap lengths. Honours SERVO_SLEW_EN the same way the design does.

module tb_motion_actuator;

    localparam int P     = 100;
    localparam int SMIN  = 10;
    localparam int SSTEP = 5;
    localparam int MP    = 20;
    localparam int DT    = 8;

    logic       clk;
    logic       rst;
    logic [2:0] dir;
    logic [1:0] speed;
    logic [1:0] choose;
    logic       servo_pwm;
    logic       motor_pwm;
    logic       motor_in1;
    logic       motor_in2;
    logic       dead_active;

    int checks   = 0;
    int failures = 0;

    motion_actuator #(
        .SERVO_PERIOD(P),
        .SERVO_MIN   (SMIN),
        .SERVO_STEP  (SSTEP),
        .MOTOR_PERIOD(MP),
        .DEADTIME    (DT)
    ) dut (
        .clk_100    (clk),
        .rst        (rst),
        .dir        (dir),
        .speed      (speed),
        .choose     (choose),
        .servo_pwm  (servo_pwm),
        .motor_pwm  (motor_pwm),
        .motor_in1  (motor_in1),
        .motor_in2  (motor_in2),
        .dead_active(dead_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Drive modes: coast, forward, reverse, brake, dead gap
    localparam int MC = 0, MF = 1, MR = 2, MB = 3, MD = 4;

    int   k;        // clocks since reset release; frame phase = k % P, PWM phase = k % MP
    int   pos_m;
    int   lvl_m;
    int   mode_m;
    int   dleft_m;  // dead-gap clocks remaining, including the current one
    bit   mv = 1'b0;
    logic e_servo, e_mpwm, e_in1, e_in2, e_dead;

    function automatic int high_time(input int l);
        case (l)
            0:       return 0;
            1:       return MP / 4;
            2:       return MP / 2;
            default: return MP;
        endcase
    endfunction

    task automatic model_step();
        int want, nmode, ph, mph, tgt;
        if (rst) begin
            k = 0; pos_m = 3; lvl_m = 0; mode_m = MC; dleft_m = 0;
            e_servo = 0; e_mpwm = 0; e_in1 = 0; e_in2 = 0; e_dead = 0;
            mv = 1'b1;
        end else begin
            ph  = k % P;
            mph = k % MP;
            case (choose)
                2'b00:   want = MC;
                2'b01:   want = MF;
                2'b10:   want = MR;
                default: want = MB;
            endcase
            if (want == MC || want == MB) begin
                nmode = want;
            end else if (mode_m == MD) begin
                if (dleft_m == 1) nmode = want;
                else begin
                    nmode = MD;
                    dleft_m--;
                end
            end else if ((mode_m == MF && want == MR) || (mode_m == MR && want == MF)) begin
                nmode   = MD;
                dleft_m = DT;
            end else begin
                nmode = want;
            end
            mode_m  = nmode;
            e_in1   = (nmode == MF || nmode == MB);
            e_in2   = (nmode == MR || nmode == MB);
            e_dead  = (nmode == MD);
            if (nmode == MB) e_mpwm = 1'b1;
            else if (nmode == MF || nmode == MR) e_mpwm = (mph < high_time(lvl_m));
            else e_mpwm = 1'b0;
            e_servo = (ph < SMIN + pos_m * SSTEP);
            if (ph == P - 1) begin
                tgt = (int'(dir) > 6) ? 6 : int'(dir);
`ifdef SERVO_SLEW_EN
                if (tgt > pos_m) pos_m++;
                else if (tgt < pos_m) pos_m--;
`else
                pos_m = tgt;
`endif
            end
            if (mph == MP - 1) lvl_m = int'(speed);
            k++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (mv) begin
            chk1("servo_pwm", servo_pwm, e_servo);
            chk1("motor_pwm", motor_pwm, e_mpwm);
            chk1("motor_in1", motor_in1, e_in1);
            chk1("motor_in2", motor_in2, e_in2);
            chk1("dead_active", dead_active, e_dead);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Measure the next servo pulse width; optionally change dir after change_at high clocks.
    task automatic next_pulse(input int change_at, input logic [2:0] new_dir, output int w);
        int n;
        n = 0;
        w = 0;
        while (servo_pwm === 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (servo_pwm !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (servo_pwm === 1'b1 && n < 400) begin
            w++;
            if (w == change_at) dir = new_dir;
            @(negedge clk);
            n++;
        end
        if (n >= 400) w = -1;
    endtask

    task automatic count_high_motor(input int len, output int c);
        c = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (motor_pwm === 1'b1) c++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int w;
        int c;
        int exp_a[3];
        rst = 1'b1; dir = 3'd3; speed = 2'd0; choose = 2'b00;
        repeat (3) @(negedge clk);
        chk1("reset_servo", servo_pwm, 1'b0);
        chk1("reset_mpwm", motor_pwm, 1'b0);
        chk1("reset_in1", motor_in1, 1'b0);
        chk1("reset_in2", motor_in2, 1'b0);
        chk1("reset_dead", dead_active, 1'b0);
        rst = 1'b0;

        // Straight ahead: 10 + 3*5 = 25 clocks
        next_pulse(-1, 3'd0, w); chkn("pulse_straight_1", w, 25);
        next_pulse(-1, 3'd0, w); chkn("pulse_straight_2", w, 25);
        chk1("coast_in1", motor_in1, 1'b0);
        chk1("coast_in2", motor_in2, 1'b0);

        // dir=110 mid-pulse: current pulse unaffected
        next_pulse(5, 3'd6, w); chkn("pulse_midframe", w, 25);
`ifdef SERVO_SLEW_EN
        exp_a = '{30, 35, 40};
`else
        exp_a = '{40, 40, 40};
`endif
        for (int i = 0; i < 3; i++) begin
            next_pulse(-1, 3'd0, w);
            chkn($sformatf("pulse_right_%0d", i), w, exp_a[i]);
        end

        // Back to straight, then 111 must clamp to the 110 width
        dir = 3'd3;
        for (int i = 0; i < 3; i++) next_pulse(-1, 3'd0, w);
        chkn("pulse_back_straight", w, 25);
        dir = 3'd7;
        for (int i = 0; i < 3; i++) next_pulse(-1, 3'd0, w);
        chkn("pulse_dir7", w, 40);

        // Forward at duty levels 1/2/3: 5/10/20 of 20
        choose = 2'b01;
        speed  = 2'd1;
        repeat (45) @(negedge clk);
        count_high_motor(MP, c); chkn("duty_lvl1", c, 5);
        chk1("fwd_in1", motor_in1, 1'b1);
        chk1("fwd_in2", motor_in2, 1'b0);
        speed = 2'd2;
        repeat (45) @(negedge clk);
        count_high_motor(MP, c); chkn("duty_lvl2", c, 10);
        speed = 2'd3;
        repeat (45) @(negedge clk);
        count_high_motor(MP, c); chkn("duty_lvl3", c, 20);

        // FWD -> REV passes through an 8-clock dead gap
        choose = 2'b10;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dead_active === 1'b1) c++;
        end
        chkn("dead_len_fwd_rev", c, 8);
        chk1("rev_in1", motor_in1, 1'b0);
        chk1("rev_in2", motor_in2, 1'b1);
        chk1("rev_mpwm", motor_pwm, 1'b1);

        // Brake requested mid-gap takes effect on the next clock
        choose = 2'b01;
        repeat (3) @(negedge clk);
        chk1("dead_mid_flag", dead_active, 1'b1);
        choose = 2'b11;
        @(negedge clk);
        chk1("brake_in1", motor_in1, 1'b1);
        chk1("brake_in2", motor_in2, 1'b1);
        chk1("brake_mpwm", motor_pwm, 1'b1);
        chk1("brake_dead", dead_active, 1'b0);

        // Flipping the request within the gap does not restart it
        choose = 2'b01;
        repeat (5) @(negedge clk);
        choose = 2'b10;
        c = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dead_active === 1'b1) c++;
        end
        choose = 2'b01;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dead_active === 1'b1) c++;
        end
        chkn("dead_len_no_restart", c, 8);
        chk1("after_flip_in1", motor_in1, 1'b1);

        // Reset in the middle of a dead gap and mid servo frame
        choose = 2'b10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mid_servo", servo_pwm, 1'b0);
        chk1("rst_mid_mpwm", motor_pwm, 1'b0);
        chk1("rst_mid_in1", motor_in1, 1'b0);
        chk1("rst_mid_in2", motor_in2, 1'b0);
        chk1("rst_mid_dead", dead_active, 1'b0);
        rst    = 1'b0;
        choose = 2'b00;
        next_pulse(-1, 3'd0, w); chkn("post_reset_pulse", w, 25);
        next_pulse(-1, 3'd0, w);
`ifdef SERVO_SLEW_EN
        chkn("post_reset_pulse_2", w, 30);
`else
        chkn("post_reset_pulse_2", w, 40);
`endif
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
